ppc_fetch_queue: RTL and testbench
==================================

Name: ppc_fetch_queue

Overview:
- Parametrised instruction-fetch front end for the PowerPC core family.
- Replaces the single-shot F state with a decoupled prefetcher. It issues doubleword reads to the shared `mem` instruction port, splits each doubleword into one or two 32-bit instructions and buffers them with their PCs in a DEPTH-entry FIFO.
- Decode consumes the FIFO through a valid/ready handshake.
- Execute/WB redirects the fetch stream on taken branches.

Parameters:
- DEPTH, 4: FIFO entries (instructions). Power of two, ≥2.
- ADDR_W, 64: PC width.
- RESET_PC, 0: fetch address after reset. Bits [ADDR_W-2:ADDR_W-1] must be 0.

Ports:
All vectors are big-endian, bit 0 = MSB, as in the core.
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-high
- memReadEn  out  1  instruction-memory read request
- memReadAddr  out  ADDR_W-3  doubleword address, = fetchPC[0:ADDR_W-4]
- memReadData  in  64  read data, valid exactly 1 cycle after memReadEn
- instValid  out  1  FIFO head valid
- inst  out  32  head instruction
- instPC  out  ADDR_W  head instruction address
- instReady  in  1  decode accepts head this cycle
- redirectEn  in  1  taken branch/flush
- redirectPC  in  ADDR_W  new fetch address; low 2 bits ignored (forced 0)
- count  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset, asynchronous, while high:
  - fetchPC=RESET_PC; FIFO empty; count=0; instValid=0.
  - memReadEn=0; inflight=0; inst and instPC = 0.
- Request rule (combinational):
  - memReadEn = ~reset & ~redirectEn & (DEPTH − count − 2·inflight ≥ 2).
  - At most one read in flight beyond the current cycle, so the core's 1-cycle memory needs no extra tracking.
- On the cycle memReadEn=1, the block registers:
  - inflight=1
  - reqPC=fetchPC
  - fetchPC advances to {fetchPC[0:ADDR_W-4]+1, 3'b000}, i.e. the next doubleword; a request from the upper word also advances to the next doubleword.
- Response (cycle after request, inflight=1):
  - If reqPC[ADDR_W-3]=0: push memReadData[0:31] @reqPC, then memReadData[32:63] @reqPC+4. Two pushes, in that order.
  - If reqPC[ADDR_W-3]=1: push only memReadData[32:63] @reqPC. One push.
  - inflight clears.
- Pop: instValid & instReady removes the head.
  - Push and pop in the same cycle are both performed.
  - count_next = count + pushes − pop.
- Never overflow. The request rule reserves slots, so a push into a full FIFO is impossible. The bench asserts count ≤ DEPTH every cycle.
- Head outputs:
  - inst/instPC come directly from the head register.
  - instValid = (count ≠ 0). There is no bypass from memReadData to the head, so empty→valid takes 1 cycle after the response.
- Redirect (redirectEn=1), highest priority:
  - Next edge: FIFO cleared (count=0), fetchPC={redirectPC[0:ADDR_W-3],2'b00}.
  - Any response arriving next cycle for a pre-redirect request is discarded (inflight cleared, epoch bit toggled/compared).
  - A pop in the redirect cycle is still reported as accepted by the consumer but has no further effect.
  - memReadEn is forced 0 in the redirect cycle; the first new request issues the following cycle.
- PC wrap: fetchPC increments modulo 2^ADDR_W, with no special handling.
- Reset asserted mid-operation clears everything immediately. A response landing after reset deassertion with inflight=0 is ignored.
- Throughput: sustains 1 instruction/cycle to decode when DEPTH≥4 and instReady is held high.

Test Plan:
- Reset then idle consumer (instReady=0), mem word @0 = 0x38600001_38800002:
  - First request at cycle 1, addr 0.
  - After response: count=2, inst=0x38600001 instPC=0, then 0x38800002 instPC=4.
  - Requests stop once count+2·inflight > DEPTH−2 (count=4, DEPTH=4).
- Streaming with instReady=1 over 16 sequential instructions:
  - instPC sequence 0,4,8,…,60 with no gaps after the first valid.
  - No duplicate or lost instruction.
- Redirect to 0x106 (odd word) while a request is in flight:
  - In-flight data dropped; FIFO empty next cycle.
  - Next request addr = 0x106>>3 = 0x20; only upper word pushed, with instPC=0x104.
  - Then instPC 0x108, 0x10C.
- Random instReady (50%) for 1000 instructions versus a reference PC counter:
  - Order and PC match.
  - count never exceeds DEPTH.
  - memReadEn never asserted with inflight=1 when count+2 > DEPTH−2.
- Asynchronous reset pulse mid-cycle during a response:
  - Outputs zero immediately.
  - After release, fetch restarts at RESET_PC and the stale response is not pushed.
- Wrap test, ADDR_W=64, redirectPC=0xFFFF_FFFF_FFFF_FFF8:
  - instPCs …FFF8, …FFFC, then 0x0, 0x4.

Source files
------------

// File: rtl/ppc_fetch_queue.sv
// Decoupled instruction prefetcher: issues doubleword reads, splits them into
// 32-bit instructions and queues them with their PCs for decode (MSB-first vectors).
module ppc_fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   memReadEn,
  output logic [ADDR_W-4:0]      memReadAddr,
  input  logic [63:0]            memReadData,
  output logic                   instValid,
  output logic [31:0]            inst,
  output logic [ADDR_W-1:0]      instPC,
  input  logic                   instReady,
  input  logic                   redirectEn,
  input  logic [ADDR_W-1:0]      redirectPC,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 2;
  localparam logic [ADDR_W-4:0] DW_ONE = (ADDR_W-3)'(1'b1);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_inflight;
  logic              r_epoch;
  logic              r_req_epoch;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_valid;
  logic [31:0]       r_head_inst;
  logic [ADDR_W-1:0] r_head_pc;
  logic [31:0]       r_mem_inst [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc   [DEPTH];

  logic [SUM_W-1:0]  w_need;
  logic              w_req;
  logic              w_resp;
  logic              w_upper;
  logic              w_pop;
  logic [1:0]        w_npush;
  logic [31:0]       w_push0_inst;
  logic [31:0]       w_push1_inst;
  logic [ADDR_W-1:0] w_push0_pc;
  logic [ADDR_W-1:0] w_push1_pc;
  logic [PTR_W-1:0]  w_wr_ptr1;
  logic [PTR_W-1:0]  w_wr_ptr_next;
  logic [PTR_W-1:0]  w_rd_ptr_next;
  logic [CNT_W-1:0]  w_count_next;
  logic [31:0]       w_head_inst_next;
  logic [ADDR_W-1:0] w_head_pc_next;
  logic              w_unused_redirect_lo;

  assign w_unused_redirect_lo = ^redirectPC[1:0];

  // Request gate: a read only issues when both slots it may fill are already free.
  always_comb begin
    w_need = {2'b00, r_count} + SUM_W'({r_inflight, 1'b0}) + SUM_W'(2'b10);
    w_req  = 1'b0;
    if (!reset && !redirectEn && (w_need <= SUM_W'(DEPTH))) begin
      w_req = 1'b1;
    end else begin
      w_req = 1'b0;
    end
  end

  // Response decode: upper-word requests push one instruction, aligned ones push two.
  always_comb begin
    w_upper      = r_req_pc[2];
    w_resp       = r_inflight & (r_req_epoch == r_epoch) & ~redirectEn;
    w_push0_pc   = r_req_pc;
    w_push1_pc   = {r_req_pc[ADDR_W-1:3], 3'b100};
    w_push1_inst = memReadData[31:0];
    w_push0_inst = memReadData[63:32];
    w_npush      = 2'd0;
    w_pop        = r_valid & instReady & ~redirectEn;
    if (w_upper) begin
      w_push0_inst = memReadData[31:0];
    end else begin
      w_push0_inst = memReadData[63:32];
    end
    if (!w_resp) begin
      w_npush = 2'd0;
    end else if (w_upper) begin
      w_npush = 2'd1;
    end else begin
      w_npush = 2'd2;
    end
  end

  // Queue bookkeeping and next head, including a head that is being written this cycle.
  always_comb begin
    w_wr_ptr1        = r_wr_ptr + PTR_W'(1'b1);
    w_wr_ptr_next    = r_wr_ptr + PTR_W'(w_npush);
    w_rd_ptr_next    = r_rd_ptr + PTR_W'(w_pop);
    w_count_next     = r_count + CNT_W'(w_npush) - CNT_W'(w_pop);
    w_head_inst_next = r_mem_inst[w_rd_ptr_next];
    w_head_pc_next   = r_mem_pc[w_rd_ptr_next];
    if ((w_npush != 2'd0) && (w_rd_ptr_next == r_wr_ptr)) begin
      w_head_inst_next = w_push0_inst;
      w_head_pc_next   = w_push0_pc;
    end else if ((w_npush == 2'd2) && (w_rd_ptr_next == w_wr_ptr1)) begin
      w_head_inst_next = w_push1_inst;
      w_head_pc_next   = w_push1_pc;
    end else begin
      w_head_inst_next = r_mem_inst[w_rd_ptr_next];
      w_head_pc_next   = r_mem_pc[w_rd_ptr_next];
    end
  end

  // Fetch state, pointers and registered head; redirect flushes and bumps the epoch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc  <= RESET_PC;
      r_req_pc    <= {ADDR_W{1'b0}};
      r_inflight  <= 1'b0;
      r_epoch     <= 1'b0;
      r_req_epoch <= 1'b0;
      r_rd_ptr    <= {PTR_W{1'b0}};
      r_wr_ptr    <= {PTR_W{1'b0}};
      r_count     <= {CNT_W{1'b0}};
      r_valid     <= 1'b0;
      r_head_inst <= 32'h0;
      r_head_pc   <= {ADDR_W{1'b0}};
    end else if (redirectEn) begin
      r_fetch_pc  <= {redirectPC[ADDR_W-1:2], 2'b00};
      r_inflight  <= 1'b0;
      r_epoch     <= ~r_epoch;
      r_rd_ptr    <= {PTR_W{1'b0}};
      r_wr_ptr    <= {PTR_W{1'b0}};
      r_count     <= {CNT_W{1'b0}};
      r_valid     <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_fetch_pc  <= {r_fetch_pc[ADDR_W-1:3] + DW_ONE, 3'b000};
        r_req_pc    <= r_fetch_pc;
        r_req_epoch <= r_epoch;
      end
      r_rd_ptr    <= w_rd_ptr_next;
      r_wr_ptr    <= w_wr_ptr_next;
      r_count     <= w_count_next;
      r_valid     <= (w_count_next != {CNT_W{1'b0}});
      r_head_inst <= w_head_inst_next;
      r_head_pc   <= w_head_pc_next;
    end
  end

  // Instruction/PC storage, written by up to two pushes per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_inst[i] <= 32'h0;
        r_mem_pc[i]   <= {ADDR_W{1'b0}};
      end
    end else begin
      if (w_npush != 2'd0) begin
        r_mem_inst[r_wr_ptr] <= w_push0_inst;
        r_mem_pc[r_wr_ptr]   <= w_push0_pc;
      end
      if (w_npush == 2'd2) begin
        r_mem_inst[w_wr_ptr1] <= w_push1_inst;
        r_mem_pc[w_wr_ptr1]   <= w_push1_pc;
      end
    end
  end

  assign memReadEn   = w_req;
  assign memReadAddr = r_fetch_pc[ADDR_W-1:3];
  assign instValid   = r_valid;
  assign inst        = r_head_inst;
  assign instPC      = r_head_pc;
  assign count       = r_count;

endmodule

// File: tb/tb_ppc_fetch_queue.sv
// Self-checking bench for ppc_fetch_queue: a 1-cycle memory model feeds the DUT,
// and accepted instructions are checked against a sequential PC stream model.
module tb_ppc_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        memReadEn;
  logic [60:0] memReadAddr;
  logic [63:0] memReadData;
  logic        instValid;
  logic [31:0] inst;
  logic [63:0] instPC;
  logic        instReady;
  logic        redirectEn;
  logic [63:0] redirectPC;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  ppc_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .memReadEn(memReadEn), .memReadAddr(memReadAddr),
    .memReadData(memReadData), .instValid(instValid), .inst(inst), .instPC(instPC),
    .instReady(instReady), .redirectEn(redirectEn), .redirectPC(redirectPC), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_at(input logic [63:0] pc);
    if (pc == 64'h0) return 32'h3860_0001;
    else if (pc == 64'h4) return 32'h3880_0002;
    else return (pc[31:0] * 32'h9E37_79B1) ^ pc[63:32] ^ 32'h1234_5678;
  endfunction

  // memory: data for the requested doubleword appears one cycle later, noise otherwise
  always @(posedge clk) begin
    if (memReadEn === 1'b1)
      memReadData <= {inst_at({memReadAddr, 3'b000}), inst_at({memReadAddr, 3'b100})};
    else
      memReadData <= {$urandom, $urandom};
  end

  task automatic do_redirect(input logic [63:0] pc);
    @(negedge clk);
    redirectEn = 1'b1; redirectPC = pc; instReady = 1'b0;
    @(negedge clk);
    redirectEn = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; instReady = 1'b0; redirectEn = 1'b0; redirectPC = 64'h0;
    repeat (2) @(negedge clk);
    checks++; if (instValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instValid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (memReadEn !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", memReadEn); end
    checks++; if (inst !== 32'h0 || instPC !== 64'h0) begin errors++; $display("FAIL reset_head: got %h @%h expected 0 @0", inst, instPC); end
    reset = 1'b0; #1;
    checks++; if (memReadEn !== 1'b1 || memReadAddr !== 61'h0) begin errors++; $display("FAIL first_req: got en=%b addr=%h expected 1/0", memReadEn, memReadAddr); end
  endtask

  task automatic test_fill_idle;
    int cyc = 0;
    @(negedge clk);
    while (instValid !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
    checks++; if (instValid !== 1'b1) begin errors++; $display("FAIL fill_timeout: got valid=%b expected 1", instValid); end
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL fill_count2: got %0d expected 2", count); end
    checks++; if (inst !== 32'h3860_0001 || instPC !== 64'h0) begin errors++; $display("FAIL fill_head0: got %h @%h expected 38600001 @0", inst, instPC); end
    checks++; if (memReadEn !== 1'b0) begin errors++; $display("FAIL fill_gate2: got %b expected 0", memReadEn); end
    @(negedge clk);
    checks++; if (count !== 3'd4 || memReadEn !== 1'b0) begin errors++; $display("FAIL fill_full: got count=%0d en=%b expected 4/0", count, memReadEn); end
    repeat (3) @(negedge clk);
    checks++; if (count !== 3'd4 || memReadEn !== 1'b0) begin errors++; $display("FAIL fill_hold: got count=%0d en=%b expected 4/0", count, memReadEn); end
    instReady = 1'b1; @(negedge clk); instReady = 1'b0;
    checks++; if (count !== 3'd3 || inst !== 32'h3880_0002 || instPC !== 64'h4 || memReadEn !== 1'b0) begin
      errors++; $display("FAIL pop1: got count=%0d %h @%h en=%b expected 3 38800002 @4 en=0", count, inst, instPC, memReadEn); end
    instReady = 1'b1; @(negedge clk); instReady = 1'b0;
    checks++; if (count !== 3'd2 || inst !== inst_at(64'h8) || instPC !== 64'h8 || memReadEn !== 1'b1) begin
      errors++; $display("FAIL pop2: got count=%0d %h @%h en=%b expected 2 %h @8 en=1", count, inst, instPC, memReadEn, inst_at(64'h8)); end
  endtask

  task automatic test_stream;
    logic [63:0] exp_pc = 64'h0;
    int got = 0, gaps = 0;
    bit started = 1'b0;
    do_redirect(64'h0);
    for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
      instReady = 1'b1; #1;
      if (instValid === 1'b1) begin
        started = 1'b1;
        checks++; if (instPC !== exp_pc || inst !== inst_at(exp_pc)) begin
          errors++; $display("FAIL stream_data: got %h @%h expected %h @%h", inst, instPC, inst_at(exp_pc), exp_pc); end
        exp_pc += 64'd4; got++;
      end else if (started) gaps++;
      @(negedge clk);
    end
    checks++; if (got != 16) begin errors++; $display("FAIL stream_timeout: got %0d expected 16", got); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps: got %0d expected 0", gaps); end
  endtask

  task automatic test_redirect_inflight;
    logic [63:0] exp_pc = 64'h104;
    int got = 0, cyc = 0;
    do_redirect(64'h0);
    @(negedge clk);
    redirectEn = 1'b1; redirectPC = 64'h106; #1;
    checks++; if (memReadEn !== 1'b0) begin errors++; $display("FAIL redir_en: got %b expected 0", memReadEn); end
    @(negedge clk); redirectEn = 1'b0; #1;
    checks++; if (count !== 3'd0 || instValid !== 1'b0) begin errors++; $display("FAIL redir_flush: got count=%0d valid=%b expected 0/0", count, instValid); end
    checks++; if (memReadEn !== 1'b1 || memReadAddr !== 61'h20) begin errors++; $display("FAIL redir_req: got en=%b addr=%h expected 1/20", memReadEn, memReadAddr); end
    @(negedge clk);
    while (instValid !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
    checks++; if (count !== 3'd1 || instPC !== 64'h104 || inst !== inst_at(64'h104)) begin
      errors++; $display("FAIL redir_upper: got count=%0d %h @%h expected 1 %h @104", count, inst, instPC, inst_at(64'h104)); end
    for (int c = 0; c < 20 && got < 3; c++) begin
      instReady = 1'b1; #1;
      if (instValid === 1'b1) begin
        checks++; if (instPC !== exp_pc || inst !== inst_at(exp_pc)) begin
          errors++; $display("FAIL redir_seq: got %h @%h expected %h @%h", inst, instPC, inst_at(exp_pc), exp_pc); end
        exp_pc += 64'd4; got++;
      end
      @(negedge clk);
    end
    checks++; if (got != 3) begin errors++; $display("FAIL redir_timeout: got %0d expected 3", got); end
  endtask

  task automatic test_random;
    logic [63:0] start, exp_pc;
    int m_count = 0, m_infl = 0, pushes, got = 0;
    bit first_resp = 1'b1, rdy;
    logic exp_en;
    start = {$urandom, $urandom} & ~64'h3;
    exp_pc = start;
    do_redirect(start);
    for (int cyc = 0; cyc < 10000 && got < 1000; cyc++) begin
      rdy = 1'($urandom_range(0, 1));
      instReady = rdy; #1;
      exp_en = (m_count + 2 * m_infl + 2 <= DEPTH);
      checks++; if (count !== 3'(m_count)) begin errors++; $display("FAIL rnd_count: got %0d expected %0d", count, m_count); end
      checks++; if (count > 3'(DEPTH)) begin errors++; $display("FAIL rnd_overflow: got %0d expected <= %0d", count, DEPTH); end
      checks++; if (instValid !== (m_count != 0)) begin errors++; $display("FAIL rnd_valid: got %b expected %b", instValid, m_count != 0); end
      checks++; if (memReadEn !== exp_en) begin errors++; $display("FAIL rnd_req: got %b expected %b", memReadEn, exp_en); end
      if (m_count != 0 && rdy) begin
        checks++; if (instPC !== exp_pc || inst !== inst_at(exp_pc)) begin
          errors++; $display("FAIL rnd_data: got %h @%h expected %h @%h", inst, instPC, inst_at(exp_pc), exp_pc); end
        exp_pc += 64'd4; got++;
      end
      pushes = (m_infl != 0) ? ((first_resp && start[2]) ? 1 : 2) : 0;
      if (m_infl != 0) first_resp = 1'b0;
      m_count = m_count + pushes - ((m_count != 0 && rdy) ? 1 : 0);
      m_infl = exp_en ? 1 : 0;
      @(negedge clk);
    end
    checks++; if (got != 1000) begin errors++; $display("FAIL rnd_timeout: got %0d expected 1000", got); end
  endtask

  task automatic test_async_reset;
    logic [63:0] exp_pc = 64'h0;
    int got = 0;
    do_redirect(64'h0);
    repeat (2) @(negedge clk);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL areset_pre: got %0d expected 2", count); end
    #1 reset = 1'b1; #1;
    checks++; if (instValid !== 1'b0 || count !== 3'd0 || memReadEn !== 1'b0) begin
      errors++; $display("FAIL areset_ctl: got valid=%b count=%0d en=%b expected 0/0/0", instValid, count, memReadEn); end
    checks++; if (inst !== 32'h0 || instPC !== 64'h0) begin errors++; $display("FAIL areset_head: got %h @%h expected 0 @0", inst, instPC); end
    #1 reset = 1'b0; #1;
    checks++; if (memReadEn !== 1'b1 || memReadAddr !== 61'h0) begin errors++; $display("FAIL areset_restart: got en=%b addr=%h expected 1/0", memReadEn, memReadAddr); end
    @(negedge clk);
    checks++; if (count !== 3'd0 || instValid !== 1'b0) begin errors++; $display("FAIL areset_stale: got count=%0d valid=%b expected 0/0", count, instValid); end
    for (int c = 0; c < 10 && got < 2; c++) begin
      instReady = 1'b1; #1;
      if (instValid === 1'b1) begin
        checks++; if (instPC !== exp_pc || inst !== inst_at(exp_pc)) begin
          errors++; $display("FAIL areset_seq: got %h @%h expected %h @%h", inst, instPC, inst_at(exp_pc), exp_pc); end
        exp_pc += 64'd4; got++;
      end
      @(negedge clk);
    end
    checks++; if (got != 2) begin errors++; $display("FAIL areset_timeout: got %0d expected 2", got); end
  endtask

  task automatic test_wrap;
    logic [63:0] exp_list [4];
    int got = 0;
    exp_list[0] = 64'hFFFF_FFFF_FFFF_FFF8; exp_list[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_list[2] = 64'h0;                   exp_list[3] = 64'h4;
    do_redirect(64'hFFFF_FFFF_FFFF_FFF8);
    for (int c = 0; c < 20 && got < 4; c++) begin
      instReady = 1'b1; #1;
      if (instValid === 1'b1) begin
        checks++; if (instPC !== exp_list[got] || inst !== inst_at(exp_list[got])) begin
          errors++; $display("FAIL wrap_seq: got %h @%h expected %h @%h", inst, instPC, inst_at(exp_list[got]), exp_list[got]); end
        got++;
      end
      @(negedge clk);
    end
    checks++; if (got != 4) begin errors++; $display("FAIL wrap_timeout: got %0d expected 4", got); end
  endtask

  initial begin
    test_reset;
    test_fill_idle;
    test_stream;
    test_redirect_inflight;
    test_random;
    test_async_reset;
    test_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
